i2c_bus_arbiter: RTL and testbench

//  Shares the single i2c_controller between two requesters: port 0 (power-up codec config sequencer)
//  and port 1 (runtime writes, e.g. volume/mute). Round-robin grant, one 24-bit I2C write per grant.

---
 rtl/i2c_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between two write requesters.
// One 24-bit write per grant, with NACK retry, hang timeout and a per-request result pulse.
module i2c_bus_arbiter #(
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic [1:0]  rdone,
    output logic        rok,
    output logic [23:0] i2c_data,
    output logic        i2c_start,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy,
    output logic        grant_id,
    output logic        timeout,
    output logic [7:0]  err_count
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StSettle,
        StWait,
        StReport
    } state_e;

    state_e            state_q, state_d;
    logic [23:0]       data_q, data_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [1:0]        rdone_q, rdone_d;
    logic              rok_q, rok_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        err_q, err_d;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        rdone_d   = 2'b00;
        rok_d     = rok_q;
        timeout_d = 1'b0;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                // i2c_done low here means a transfer from before a reset is still on the bus
                if ((|req) && i2c_done) begin
                    grant_d = (req == 2'b11) ? ~last_q : req[1];
                    data_d  = grant_d ? data1 : data0;
                    retry_d = '0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                tmo_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                state_d = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + 16'd1;
                if (i2c_done) begin
                    if (i2c_ack) begin
                        state_d = StReport;
                        rdone_d = grant_q ? 2'b10 : 2'b01;
                        rok_d   = 1'b1;
                    end else if (retry_q < RetryMax) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StLaunch;
                    end else begin
                        state_d = StReport;
                        rdone_d = grant_q ? 2'b10 : 2'b01;
                        rok_d   = 1'b0;
                        if (err_q != 8'hff) err_d = err_q + 8'd1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d   = StReport;
                    rdone_d   = grant_q ? 2'b10 : 2'b01;
                    rok_d     = 1'b0;
                    timeout_d = 1'b1;
                    if (err_q != 8'hff) err_d = err_q + 8'd1;
                end
            end
            StReport: begin
                last_d  = grant_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            data_q    <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            retry_q   <= '0;
            tmo_q     <= '0;
            rdone_q   <= 2'b00;
            rok_q     <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            rdone_q   <= rdone_d;
            rok_q     <= rok_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign i2c_start = (state_q == StLaunch);
    assign busy      = (state_q != StIdle);
    assign i2c_data  = data_q;
    assign grant_id  = grant_q;
    assign rdone     = rdone_q;
    assign rok       = rok_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: directed requests against a scripted controller model,
// expectations queued at stimulus time and checked by an independent monitor on rdone/i2c_start.
module tb_i2c_bus_arbiter;

    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [1:0]  req;
    logic [23:0] data0 = 24'h0;
    logic [23:0] data1 = 24'h0;
    logic [1:0]  rdone;
    logic        rok;
    logic [23:0] i2c_data;
    logic        i2c_start;
    logic        i2c_done = 1'b1;
    logic        i2c_ack = 1'b0;
    logic        busy;
    logic        grant_id;
    logic        timeout;
    logic [7:0]  err_count;

    assign req = {req1, req0};

    i2c_bus_arbiter #(
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .rdone     (rdone),
        .rok       (rok),
        .i2c_data  (i2c_data),
        .i2c_start (i2c_start),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .grant_id  (grant_id),
        .timeout   (timeout),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   delay;
        logic ack;
        logic hang;
    } resp_t;

    typedef struct {
        logic [1:0]  rdone;
        logic        rok;
        logic        tmo;
        logic [23:0] data;
        int          starts;
        int          lat;
        int          gap;
        logic [7:0]  err;
    } exp_t;

    resp_t resp_q[$];
    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Controller model: each start pops a scripted response (delay to done, ack, or hang)
    int    ctl_cnt = 0;
    logic  ctl_active = 1'b0;
    logic  ctl_hang = 1'b0;
    logic  ctl_ack = 1'b0;
    logic  ctl_release = 1'b0;
    resp_t cur_r;

    initial forever begin
        @(negedge clk);
        if (i2c_start) begin
            i2c_done   = 1'b0;
            i2c_ack    = 1'b0;
            ctl_active = 1'b1;
            if (resp_q.size() > 0) begin
                cur_r    = resp_q.pop_front();
                ctl_cnt  = cur_r.delay;
                ctl_ack  = cur_r.ack;
                ctl_hang = cur_r.hang;
            end else begin
                ctl_hang = 1'b1;
            end
        end else if (ctl_active && ctl_hang) begin
            if (ctl_release) begin
                i2c_done   = 1'b1;
                i2c_ack    = 1'b1;
                ctl_active = 1'b0;
            end
        end else if (ctl_active) begin
            ctl_cnt--;
            if (ctl_cnt <= 0) begin
                i2c_done   = 1'b1;
                i2c_ack    = ctl_ack;
                ctl_active = 1'b0;
            end
        end
    end

    // Monitor
    int   starts = 0;
    int   last_start_cyc = 0;
    int   last_rdone_cyc = 0;
    exp_t e;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            starts = 0;
        end else begin
            if (timeout && rdone == 2'b00) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout_alone: got timeout=1 rdone=00, expected timeout only with rdone");
            end
            if (i2c_start) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start: got i2c_start=1, expected none (cycle %0d)", cyc);
                end else begin
                    if (starts == 0 && exp_q[0].gap >= 0)
                        chk("grant_gap", 32'(cyc - last_rdone_cyc), 32'(exp_q[0].gap));
                    chk("start_data", 32'(i2c_data), 32'(exp_q[0].data));
                end
                starts++;
                last_start_cyc = cyc;
            end
            if (rdone != 2'b00) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rdone: got rdone=%b, expected none (cycle %0d)", rdone, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdone", 32'(rdone), 32'(e.rdone));
                    chk("rok", 32'(rok), 32'(e.rok));
                    chk("timeout", 32'(timeout), 32'(e.tmo));
                    chk("done_data", 32'(i2c_data), 32'(e.data));
                    chk("start_count", 32'(starts), 32'(e.starts));
                    chk("latency", 32'(cyc - last_start_cyc), 32'(e.lat));
                    chk("err_count", 32'(err_count), 32'(e.err));
                end
                starts = 0;
                last_rdone_cyc = cyc;
            end
        end
    end

    task automatic push_resp(input int delay, input logic ack, input logic hang);
        resp_t r;
        r.delay = delay;
        r.ack   = ack;
        r.hang  = hang;
        resp_q.push_back(r);
    endtask

    task automatic push_exp(input logic [1:0] rd, input logic ok, input logic tm,
                            input logic [23:0] d, input int st, input int lat, input int gap,
                            input logic [7:0] err);
        exp_t x;
        x.rdone  = rd;
        x.rok    = ok;
        x.tmo    = tm;
        x.data   = d;
        x.starts = st;
        x.lat    = lat;
        x.gap    = gap;
        x.err    = err;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise the masked requests and drop each one as soon as its rdone is seen
    task automatic serve(input logic [1:0] mask, input int budget);
        logic [1:0] pending;
        pending = mask;
        if (mask[0]) req0 = 1'b1;
        if (mask[1]) req1 = 1'b1;
        for (int i = 0; i < budget && pending != 2'b00; i++) begin
            @(negedge clk);
            if (rdone[0] && pending[0]) begin
                pending[0] = 1'b0;
                req0 = 1'b0;
            end
            if (rdone[1] && pending[1]) begin
                pending[1] = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("serve_complete", 32'(pending), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdone"}, 32'(rdone), 32'd0);
        chk({tag, "_rok"}, 32'(rok), 32'd0);
        chk({tag, "_i2c_data"}, 32'(i2c_data), 32'd0);
        chk({tag, "_i2c_start"}, 32'(i2c_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int   nstart;
        logic seen;

        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Single ACKed write from port 0
        data0 = 24'h340c10;
        push_resp(20, 1'b1, 1'b0);
        push_exp(2'b01, 1'b1, 1'b0, 24'h340c10, 1, 21, -1, 8'd0);
        serve(2'b01, 200);

        // Both ports contend: alternation starting at port 0, one IDLE cycle between grants
        do_reset();
        data0 = 24'h1a2b3c;
        data1 = 24'h4d5e6f;
        repeat (4) push_resp(3, 1'b1, 1'b0);
        push_exp(2'b01, 1'b1, 1'b0, 24'h1a2b3c, 1, 4, -1, 8'd0);
        push_exp(2'b10, 1'b1, 1'b0, 24'h4d5e6f, 1, 4, 2, 8'd0);
        push_exp(2'b01, 1'b1, 1'b0, 24'h1a2b3c, 1, 4, 2, 8'd0);
        push_exp(2'b10, 1'b1, 1'b0, 24'h4d5e6f, 1, 4, 2, 8'd0);
        serve(2'b11, 200);
        serve(2'b11, 200);

        // Persistent NACK: 1 + 3 retries, then failure
        data1 = 24'h55aa01;
        repeat (4) push_resp(3, 1'b0, 1'b0);
        push_exp(2'b10, 1'b0, 1'b0, 24'h55aa01, 4, 4, -1, 8'd1);
        serve(2'b10, 200);

        // NACK once, then ACK
        data0 = 24'h123456;
        push_resp(3, 1'b0, 1'b0);
        push_resp(5, 1'b1, 1'b0);
        push_exp(2'b01, 1'b1, 1'b0, 24'h123456, 2, 6, -1, 8'd1);
        serve(2'b01, 200);

        // Hung transfer aborted by timeout
        data0 = 24'h00beef;
        push_resp(0, 1'b0, 1'b1);
        push_exp(2'b01, 1'b0, 1'b1, 24'h00beef, 1, TMO + 2, -1, 8'd2);
        serve(2'b01, 200);
        ctl_release = 1'b1;
        repeat (2) @(negedge clk);
        ctl_release = 1'b0;

        // Done on the last WAIT cycle wins over timeout
        data1 = 24'hc0ffee;
        push_resp(TMO + 1, 1'b1, 1'b0);
        push_exp(2'b10, 1'b1, 1'b0, 24'hc0ffee, 1, TMO + 2, -1, 8'd2);
        serve(2'b10, 200);

        // Done one cycle too late: timeout
        push_resp(TMO + 2, 1'b1, 1'b0);
        push_exp(2'b01, 1'b0, 1'b1, 24'h00beef, 1, TMO + 2, -1, 8'd3);
        serve(2'b01, 200);

        // Reset in WAIT with the controller still busy
        data0 = 24'h0a0b0c;
        push_resp(0, 1'b0, 1'b1);
        push_exp(2'b01, 1'b1, 1'b0, 24'h0a0b0c, 1, 0, -1, 8'd0);
        req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = i2c_start;
        end
        chk("rst_start_seen", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_busy_in_wait", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_resp(4, 1'b1, 1'b0);
        push_exp(2'b01, 1'b1, 1'b0, 24'h0a0b0c, 1, 5, -1, 8'd0);
        nstart = 0;
        repeat (8) begin
            @(negedge clk);
            if (i2c_start) nstart++;
        end
        chk("rst_no_start_done_low", 32'(nstart), 32'd0);
        chk("rst_idle_done_low", 32'(busy), 32'd0);
        ctl_release = 1'b1;
        repeat (2) @(negedge clk);
        ctl_release = 1'b0;
        serve(2'b01, 200);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
